// File: rtl/unpack_pkg.sv
// Shared types and sizing helpers for the pack/unpack datapath blocks.
package unpack_pkg;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    // Counter width for an index range of d entries, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned d);
        return ($clog2(d) > 0) ? $clog2(d) : 1;
    endfunction

    localparam int unsigned CW = cnt_width(D);

    typedef logic [W-1:0] word_t;

endpackage

// File: rtl/unpack_cnt.sv
// Modulo-D word index: clr wins over inc, last flags the final word.
module unpack_cnt
    import unpack_pkg::*;
#(
    parameter int unsigned D  = 4,
    parameter int unsigned CW = cnt_width(D)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          last
);

    always_comb begin
        last = (cnt == CW'(D - 1));
    end

    // With D==1 last is always set, so the index stays pinned at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/unpack.sv
// Vector-to-word serializer: one D-word vector in, D words out, word 0 first.
// Define UNPACK_OVERLAP_EN to accept the next vector alongside the last word.
module unpack
    import unpack_pkg::*;
#(
    parameter int unsigned W = unpack_pkg::W,
    parameter int unsigned D = unpack_pkg::D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [D-1:0][W-1:0]   s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [W-1:0]          m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int unsigned CW = cnt_width(D);

    logic [D-1:0][W-1:0] vec_q;
    logic [D-1:0][W-1:0] vec_d;
    logic                full_q;
    logic                full_d;
    logic [CW-1:0]       cnt;
    logic                last;
    logic                s_fire;
    logic                m_fire;

    unpack_cnt #(
        .D  (D),
        .CW (CW)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (m_fire),
        .clr  (s_fire),
        .cnt  (cnt),
        .last (last)
    );

    // Handshake decode and next-state; a load takes priority over draining.
    always_comb begin
        m_valid = full_q;
        m_data  = vec_q[cnt];
`ifdef UNPACK_OVERLAP_EN
        s_ready = !full_q || (last && m_ready);
`else
        s_ready = !full_q;
`endif
        s_fire  = s_valid && s_ready;
        m_fire  = full_q && m_ready;
        full_d  = full_q;
        vec_d   = vec_q;
        if (s_fire) begin
            full_d = 1'b1;
            vec_d  = s_data;
        end else if (m_fire && last) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= 1'b0;
            vec_q  <= '0;
        end else begin
            full_q <= full_d;
            vec_q  <= vec_d;
        end
    end

endmodule

// File: tb/tb_unpack.sv
// Directed and random-handshake checks for the unpack serializer.
module tb_unpack;
    import unpack_pkg::*;

    localparam int BUDGET = 5000;

    logic                clk = 1'b0;
    logic                rst;
    logic [D-1:0][W-1:0] s_data;
    logic                s_valid;
    logic                s_ready;
    logic [W-1:0]        m_data;
    logic                m_valid;
    logic                m_ready;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    word_t rx_q[$];
    int    rx_cyc[$];
    word_t exp_q[$];

    unpack #(.W(W), .D(D)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every word that will transfer on the coming rising edge.
    always @(negedge clk) begin
        if (rst && m_valid && m_ready) begin
            rx_q.push_back(m_data);
            rx_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rx_q.delete();
        rx_cyc.delete();
        exp_q.delete();
    endtask

    task automatic apply_reset();
        rst     = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    // Offer one vector and hold it until accepted; expected words logged in order.
    task automatic s_xmt(input logic [D-1:0][W-1:0] v);
        s_valid = 1'b1;
        s_data  = v;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (s_ready) begin
                tick();
                s_valid = 1'b0;
                for (int k = 0; k < int'(D); k++) exp_q.push_back(v[k]);
                return;
            end
        end
        check("s_xmt_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
    endtask

    task automatic wait_words(input int n);
        for (int i = 0; i < BUDGET; i++) begin
            if (rx_q.size() >= n) return;
            @(posedge clk);
        end
        check("wait_timeout", 32'(rx_q.size()), 32'(n));
    endtask

    task automatic check_words(input string tag);
        check({tag, "_n"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) check(tag, 32'(rx_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic run_random(input string tag);
        clear_logs();
        fork
            begin
                for (int v = 0; v < 8; v++) begin
                    logic [D-1:0][W-1:0] d;
                    for (int k = 0; k < int'(D); k++) d[k] = W'($urandom);
                    s_xmt(d);
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
            begin
                for (int i = 0; i < BUDGET; i++) begin
                    if (rx_q.size() >= 8 * int'(D)) break;
                    m_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                m_ready = 1'b0;
            end
        join
        repeat (4) tick();
        check_words(tag);
    endtask

    initial begin
        logic [D-1:0][W-1:0] v;
        rst     = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        #12;
        check("rst_state", 32'({m_valid, s_ready, m_data}), 32'({1'b0, 1'b1, 8'h00}));
        tick();
        rst = 1'b1;
        tick();

        // 1) single vector, free-running consumer
        clear_logs();
        m_ready = 1'b1;
        s_xmt({8'h44, 8'h33, 8'h22, 8'h11});
        wait_words(4);
        @(negedge clk);
        check("t1_drain_valid", 32'(m_valid), 32'd0);
        check("t1_n", 32'(rx_q.size()), 32'd4);
        if (rx_q.size() >= 4) begin
            check("t1_w0", 32'(rx_q[0]), 32'h11);
            check("t1_w1", 32'(rx_q[1]), 32'h22);
            check("t1_w2", 32'(rx_q[2]), 32'h33);
            check("t1_w3", 32'(rx_q[3]), 32'h44);
        end
        tick();

        // 2) random vectors with random backpressure
        run_random("t2_rnd");

        // 3) stall while word 1 is presented
        clear_logs();
        m_ready = 1'b0;
        s_xmt({8'hd4, 8'hc3, 8'hb2, 8'ha1});
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("t3_stall", 32'({m_valid, s_ready, m_data}), 32'({1'b1, 1'b0, 8'hb2}));
        end
        tick();
        m_ready = 1'b1;
        wait_words(4);
        repeat (2) tick();
        check_words("t3_resume");

        // 4) back-to-back vectors, measure cycle span of the 2*D words
        clear_logs();
        m_ready = 1'b1;
        s_xmt({8'h04, 8'h03, 8'h02, 8'h01});
        s_xmt({8'h08, 8'h07, 8'h06, 8'h05});
        wait_words(8);
        repeat (2) tick();
        check_words("t4_b2b");
        if (rx_cyc.size() >= 8) begin
`ifdef UNPACK_OVERLAP_EN
            check("t4_span", 32'(rx_cyc[7] - rx_cyc[0] + 1), 32'd8);
`else
            check("t4_span", 32'(rx_cyc[7] - rx_cyc[0] + 1), 32'd9);
`endif
        end

        // 5) reset mid-vector, then a fresh vector
        clear_logs();
        m_ready = 1'b1;
        s_xmt({8'h5d, 8'h5c, 8'h5b, 8'h5a});
        wait_words(2);
        #2 rst = 1'b0;
        #1;
        check("t5_async_rst", 32'({m_valid, s_ready, m_data}), 32'({1'b0, 1'b1, 8'h00}));
        tick();
        rst = 1'b1;
        clear_logs();
        repeat (2) tick();
        check("t5_no_partial", 32'(m_valid), 32'd0);
        v = {8'h6d, 8'h6c, 8'h6b, 8'h6a};
        s_xmt(v);
        wait_words(4);
        repeat (3) tick();
        check_words("t5_new");
        if (rx_q.size() >= 1) check("t5_first", 32'(rx_q[0]), 32'h6a);

        // 6) random, reset, random again
        run_random("t6_rnd_a");
        apply_reset();
        run_random("t6_rnd_b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
